digit_display_driver: RTL and testbench
=======================================

Name: digit_display_driver

Overview:
Downstream consumer of the frequency counter's BCD result: latches the tens/units digits on a load pulse and drives a two-digit multiplexed common 7-segment display. Time-multiplexes one shared segment bus between the two digits using a free-running refresh divider. Decodes BCD to segment patterns internally; outputs are fully registered and go straight to pads.

Parameters:
REFRESH_PERIOD, 100, clk cycles each digit is shown before the mux switches (must be >=2)
REFRESH_BITS, 7, width of refresh counter; must hold REFRESH_PERIOD-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe: capture ten_count/unit_count
ten_count  input  4  BCD tens digit, valid when load=1
unit_count  input  4  BCD units digit, valid when load=1
segments  output  7  active-high segment drive, bit0=a ... bit6=g
digit  output  1  digit select: 1 = tens digit shown, 0 = units digit shown

Behaviour:
- Reset (sync, active-high) clears: tens_latch=0, units_latch=0, refresh counter=0, digit=0, segments=7'b0000000 (blank). Reset overrides load and refresh in the same cycle.
- Latch: on an edge with load=1, tens_latch<=ten_count, units_latch<=unit_count. load=0 holds latches indefinitely. load held high for multiple cycles recaptures every cycle (last value wins).
- Refresh counter: counts 0..REFRESH_PERIOD-1 every cycle, wraps to 0; on the edge where it equals REFRESH_PERIOD-1, digit toggles. Each digit therefore asserted for exactly REFRESH_PERIOD cycles; first toggle occurs REFRESH_PERIOD cycles after reset release.
- Segments register updates every cycle: segments <= decode(next_digit ? tens_latch : units_latch), where next_digit is the value digit takes at that same edge and the latch values are those held before the edge. Result: digit and segments always change on the same edge, no ghosting cycle.
- Latency: load sampled at edge N -> latches update at N -> segments show new value from edge N+1 (for whichever digit is selected).
- Simultaneous load and digit toggle: toggle proceeds; segments at that edge use old latch value of newly selected digit; corrected at the following edge.
- Decode (a..g, bit0..bit6): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F. Codes 10..15 (not legal BCD) display a dash: 7'h40 (g only).
- Refresh counter and digit are unaffected by load; the mux runs continuously.

Optional Feature:
LEADING_ZERO_BLANK_EN: when defined, while digit=1 and tens_latch==0 the segments output is 7'h00 (tens blanked; e.g. "07" shows as " 7"). Units digit never blanked, so 0 displays as " 0". When undefined, tens digit 0 shows the "0" pattern 7'h3F. Timing and latency identical in both builds.

Decomposition:
- Shared package/include (freq_counter_pkg): segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK, and the digit-select encoding constants DIGIT_TENS=1, DIGIT_UNITS=0.
- One sub-module: bcd_to_7seg (purely combinational, 4-bit in, 7-bit out, uses package constants); top holds latches, refresh counter, digit flop and output register.

Test Plan:
- Reset: assert reset 3 cycles mid-operation after loading 4/2 -> segments=00, digit=0, first digit toggle exactly REFRESH_PERIOD cycles after reset release, latches read back as 0 (shows 3F on units).
- Load 4/2, REFRESH_PERIOD=4 -> from next edge units phase segments=5B, digit=0 for 4 cycles; then digit=1, segments=66 for 4 cycles; pattern repeats indefinitely without further load.
- Sweep all 16 codes on both digits -> 0..9 give 3F,06,5B,4F,66,6D,7D,07,7F,6F; 10..15 give 40.
- Load 9/9 on the exact cycle counter=REFRESH_PERIOD-1 (previous value 1/3) -> digit toggles to 1, segments=06 (old tens) for one cycle, then 6F; no lost toggle.
- Load 0/7 with and without LEADING_ZERO_BLANK_EN -> tens phase segments 00 vs 3F; units phase 07 in both; load 0/0 with macro -> tens 00, units 3F.
- load held high 3 cycles with 1/1, 2/2, 3/3 -> latches end at 3/3; displayed segments 4F on both phases afterwards.

Source files
------------

// File: rtl/freq_counter_pkg.sv
// ---------------------------------------------------------------------------
// freq_counter_pkg
//   Shared constants for the frequency-counter display path.
//   - SEG_*      : active-high 7-segment patterns, bit0=a ... bit6=g
//   - DIGIT_*    : encoding of the digit-select output
// ---------------------------------------------------------------------------
package freq_counter_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;  // non-BCD input: segment g only
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic DIGIT_TENS  = 1'b1;
    localparam logic DIGIT_UNITS = 1'b0;

endpackage

// File: rtl/bcd_to_7seg.sv
// ---------------------------------------------------------------------------
// bcd_to_7seg
//   Purely combinational BCD to 7-segment decoder.
//   Ports:
//     bcd  in  [3:0]  digit code; 10..15 are not BCD and decode to a dash
//     seg  out [6:0]  active-high segments, bit0=a ... bit6=g
// ---------------------------------------------------------------------------
module bcd_to_7seg
    import freq_counter_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/digit_display_driver.sv
// ---------------------------------------------------------------------------
// digit_display_driver
//   Latches a two-digit BCD result on a load strobe and drives a two-digit
//   multiplexed 7-segment display over one shared, fully registered segment
//   bus. A free-running refresh counter swaps the shown digit every
//   REFRESH_PERIOD cycles.
//
//   Parameters:
//     REFRESH_PERIOD  cycles each digit is shown (>= 2)
//     REFRESH_BITS    refresh counter width, must hold REFRESH_PERIOD-1
//
//   Ports:
//     clk         in   system clock, rising edge
//     reset       in   synchronous active-high reset
//     load        in   one-cycle strobe capturing ten_count/unit_count
//     ten_count   in   [3:0] BCD tens digit
//     unit_count  in   [3:0] BCD units digit
//     segments    out  [6:0] active-high segments, bit0=a ... bit6=g
//     digit       out  1 = tens shown, 0 = units shown
//
//   Build option:
//     LEADING_ZERO_BLANK_EN  when defined, a zero tens digit is blanked.
// ---------------------------------------------------------------------------
module digit_display_driver
    import freq_counter_pkg::*;
#(
    parameter int REFRESH_PERIOD = 100,
    parameter int REFRESH_BITS   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ten_count,
    input  logic [3:0] unit_count,
    output logic [6:0] segments,
    output logic       digit
);

    localparam logic [REFRESH_BITS-1:0] REFRESH_LAST = REFRESH_BITS'(REFRESH_PERIOD - 1);

    logic [3:0]              tens_q,     tens_d;
    logic [3:0]              units_q,    units_d;
    logic [REFRESH_BITS-1:0] refresh_q,  refresh_d;
    logic                    digit_q,    digit_d;
    logic [6:0]              segments_q, segments_d;

    logic                    refresh_wrap;
    logic [3:0]              shown_bcd;
    logic [6:0]              shown_seg;

    // Refresh counter and digit select run independently of load.
    always_comb begin
        refresh_wrap = (refresh_q == REFRESH_LAST);
        refresh_d    = refresh_wrap ? '0 : refresh_q + REFRESH_BITS'(1);
        digit_d      = refresh_wrap ? ~digit_q : digit_q;

        tens_d  = tens_q;
        units_d = units_q;
        if (load) begin
            tens_d  = ten_count;
            units_d = unit_count;
        end
    end

    // Decode the digit that becomes visible at this edge, using the latch
    // contents from before the edge, so digit and segments switch together.
    always_comb begin
        shown_bcd = (digit_d == DIGIT_TENS) ? tens_q : units_q;
    end

    bcd_to_7seg u_dec (
        .bcd (shown_bcd),
        .seg (shown_seg)
    );

    always_comb begin
        segments_d = shown_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if ((digit_d == DIGIT_TENS) && (tens_q == 4'd0)) begin
            segments_d = SEG_BLANK;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tens_q     <= 4'd0;
            units_q    <= 4'd0;
            refresh_q  <= '0;
            digit_q    <= DIGIT_UNITS;
            segments_q <= SEG_BLANK;
        end else begin
            tens_q     <= tens_d;
            units_q    <= units_d;
            refresh_q  <= refresh_d;
            digit_q    <= digit_d;
            segments_q <= segments_d;
        end
    end

    assign segments = segments_q;
    assign digit    = digit_q;

endmodule

// File: tb/tb_digit_display_driver.sv
// ---------------------------------------------------------------------------
// tb_digit_display_driver
//   Directed bench for digit_display_driver with REFRESH_PERIOD=4.
//   Expected values follow the hand-derived display timeline: after reset
//   release, edge n shows the tens digit when (n/4) is odd.
// ---------------------------------------------------------------------------
module tb_digit_display_driver;

    localparam int RP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic [6:0] segments;
    logic       digit;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;   // edges since reset release

    digit_display_driver #(
        .REFRESH_PERIOD (RP),
        .REFRESH_BITS   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .ten_count  (ten_count),
        .unit_count (unit_count),
        .segments   (segments),
        .digit      (digit)
    );

    always #5 clk = ~clk;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    function automatic logic [6:0] dec(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic exp_dig();
        return ((cyc / RP) % 2) == 1;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        cyc = r ? 0 : cyc + 1;
    endtask

    task automatic ld(input logic [3:0] t, input logic [3:0] u);
        load = 1'b1; ten_count = t; unit_count = u;
        tick();
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [6:0] tens_zero;
        tens_zero = LZB ? 7'h00 : 7'h3F;

        reset = 1'b1; load = 1'b0; ten_count = 4'd0; unit_count = 4'd0;
        tick(); tick();
        chk("rst_seg", 8'(segments), 8'h00);
        chk("rst_dig", 8'(digit), 8'h0);
        reset = 1'b0;

        // 4/2: first edge still shows old units (0), then the new value.
        ld(4'd4, 4'd2);
        chk("lat_old", 8'(segments), 8'h3F);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("mux_dig", 8'(digit), 8'(exp_dig()));
            chk("mux_seg", 8'(segments), exp_dig() ? 8'h66 : 8'h5B);
        end

        // Reset mid-operation, with a competing load that must be ignored.
        load = 1'b1; ten_count = 4'd5; unit_count = 4'd5;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst2_seg", 8'(segments), 8'h00);
            chk("rst2_dig", 8'(digit), 8'h0);
        end
        reset = 1'b0; load = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("rst2_units0", 8'(segments), 8'h3F);
        end while (digit !== 1'b1 && n < 20);
        chk("first_toggle", 8'(n), 8'(RP));
        chk("rst2_tens0", 8'(segments), 8'(tens_zero));

        // Sweep every code on both digits (4 edges apart = opposite digit).
        for (int c = 0; c < 16; c++) begin
            ld(4'(c), 4'(c));
            tick();
            chk("sweep_a", 8'(segments),
                (LZB && c == 0 && exp_dig()) ? 8'h00 : 8'(dec(4'(c))));
            for (int k = 0; k < RP; k++) tick();
            chk("sweep_b", 8'(segments),
                (LZB && c == 0 && exp_dig()) ? 8'h00 : 8'(dec(4'(c))));
        end

        // Load landing on the toggle edge: old tens shows for one cycle.
        ld(4'd1, 4'd3);
        n = 0;
        while (cyc % 8 != 3 && n < 16) begin tick(); n++; end
        chk("align", 8'(cyc % 8), 8'd3);
        ld(4'd9, 4'd9);
        chk("coll_dig", 8'(digit), 8'h1);
        chk("coll_seg_old", 8'(segments), 8'h06);
        tick();
        chk("coll_dig2", 8'(digit), 8'h1);
        chk("coll_seg_new", 8'(segments), 8'h6F);

        // Leading-zero handling.
        ld(4'd0, 4'd7);
        do tick(); while (cyc % 8 != 5);
        chk("lz07_tens", 8'(segments), 8'(tens_zero));
        do tick(); while (cyc % 8 != 1);
        chk("lz07_units", 8'(segments), 8'h07);
        ld(4'd0, 4'd0);
        do tick(); while (cyc % 8 != 5);
        chk("lz00_tens", 8'(segments), 8'(tens_zero));
        do tick(); while (cyc % 8 != 1);
        chk("lz00_units", 8'(segments), 8'h3F);

        // Load held three cycles: last value wins.
        load = 1'b1;
        ten_count = 4'd1; unit_count = 4'd1; tick();
        ten_count = 4'd2; unit_count = 4'd2; tick();
        ten_count = 4'd3; unit_count = 4'd3; tick();
        load = 1'b0;
        tick();
        chk("hold_seg_a", 8'(segments), 8'h4F);
        chk("hold_dig_a", 8'(digit), 8'(exp_dig()));
        for (int k = 0; k < RP; k++) tick();
        chk("hold_seg_b", 8'(segments), 8'h4F);
        chk("hold_dig_b", 8'(digit), 8'(exp_dig()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
